riscv_mem_stage: RTL

RISCV_MEM_STAGE -- requirements
Module: riscv_mem_stage

---
 rtl/riscv_mem_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/riscv_mem_stage.sv
// -----------------------------------------------------------------------------
// riscv_mem_stage
//
// MEM pipeline stage of a RISC-V core. It holds the instruction coming from EX
// in the EX/MEM register. Loads and stores go to a data memory through a
// req/gnt + rvalid handshake. Load data is lane-extracted and sign- or
// zero-extended before it is handed to writeback. Non-memory instructions pass
// through with one cycle of latency, like a plain pipeline register.
//
// Parameters
//   XLEN         datapath width, 32 or 64
//   TIMEOUT_CYC  number of RESP cycles to wait for rvalid before a bus error
//                (1..65535)
//
// Optional feature
//   RISCV_MEM_MISALIGN_EN  when defined, misaligned halfword/word/doubleword
//                          accesses are flagged and not issued. When it is
//                          undefined, the sub-size address bits are ignored
//                          and o_misalignM is always 0.
//
// Ports
//   i_clk, i_rstn            clock, synchronous active-low reset
//   i_validE / o_readyE      EX handshake; the stage accepts in IDLE or DONE
//   i_flush                  kill the instruction currently in MEM
//   i_ctrl_*E, i_funct3E,    EX-side instruction fields captured on accept
//   i_alu_resultE, ...
//   o_validM, o_*M           writeback-side view of the MEM register
//   o_mem_readdataM          extended load data
//   o_bus_errM               load response timed out
//   o_misalignM              misaligned access (feature build only)
//   o_dmem_*                 request to data memory (word-aligned address,
//                            byte lanes, lane-shifted write data)
//   i_dmem_gnt/rvalid/rdata  data memory grant and load response
// -----------------------------------------------------------------------------
module riscv_mem_stage #(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              i_clk,
    input  logic              i_rstn,

    input  logic              i_validE,
    output logic              o_readyE,
    input  logic              i_flush,
    input  logic              i_ctrl_reg_wr_enE,
    input  logic [1:0]        i_ctrl_result_srcE,
    input  logic              i_ctrl_mem_wr_enE,
    input  logic              i_ctrl_mem_rd_enE,
    input  logic [2:0]        i_funct3E,
    input  logic [XLEN-1:0]   i_alu_resultE,
    input  logic [XLEN-1:0]   i_mem_writedataE,
    input  logic [4:0]        i_regfile_rd_addrE,
    input  logic [XLEN-1:0]   i_PCPlus4E,
    input  logic [XLEN-1:0]   i_PCTargetE,

    output logic              o_validM,
    output logic              o_ctrl_reg_wr_enM,
    output logic [1:0]        o_ctrl_result_srcM,
    output logic [4:0]        o_regfile_rd_addrM,
    output logic [XLEN-1:0]   o_alu_resultM,
    output logic [XLEN-1:0]   o_PCPlus4M,
    output logic [XLEN-1:0]   o_PCTargetM,
    output logic [XLEN-1:0]   o_mem_readdataM,
    output logic              o_bus_errM,
    output logic              o_misalignM,

    output logic              o_dmem_req,
    output logic              o_dmem_wr_en,
    output logic [XLEN-1:0]   o_dmem_addr,
    output logic [XLEN/8-1:0] o_dmem_byte_sel,
    output logic [XLEN-1:0]   o_dmem_wdata,
    input  logic              i_dmem_gnt,
    input  logic              i_dmem_rvalid,
    input  logic [XLEN-1:0]   i_dmem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    // Low address bits that must be zero for an access of the given size
    // (funct3[1:0]). They are also the bits dropped from the lane offset.
    function automatic logic [2:0] size_low_bits(input logic [1:0] size);
        case (size)
            2'd0:    size_low_bits = 3'b000;
            2'd1:    size_low_bits = 3'b001;
            2'd2:    size_low_bits = 3'b011;
            default: size_low_bits = (XLEN == 64) ? 3'b111 : 3'b011;
        endcase
    endfunction

    state_t            state_reg, state_next;
    logic              valid_reg, valid_next;
    logic              kill_reg, kill_next;
    logic [15:0]       tmo_cnt_reg, tmo_cnt_next;
    logic              reg_wr_en_reg, reg_wr_en_next;
    logic [1:0]        result_src_reg, result_src_next;
    logic              mem_wr_en_reg, mem_wr_en_next;
    logic [2:0]        funct3_reg, funct3_next;
    logic [XLEN-1:0]   alu_result_reg, alu_result_next;
    logic [XLEN-1:0]   wdata_reg, wdata_next;
    logic [4:0]        rd_addr_reg, rd_addr_next;
    logic [XLEN-1:0]   pc_plus4_reg, pc_plus4_next;
    logic [XLEN-1:0]   pc_target_reg, pc_target_next;
    logic [XLEN-1:0]   readdata_reg, readdata_next;
    logic              bus_err_reg, bus_err_next;
    logic              misalign_reg, misalign_next;

    logic              capture;
    logic              e_is_mem;
    logic              e_misalign;

    assign o_readyE = (state_reg == IDLE) || (state_reg == DONE);
    assign capture  = i_validE & o_readyE;
    assign e_is_mem = i_ctrl_mem_wr_enE | i_ctrl_mem_rd_enE;

`ifdef RISCV_MEM_MISALIGN_EN
    logic [2:0] e_low_bits;
    assign e_low_bits = size_low_bits(i_funct3E[1:0]);
    assign e_misalign = e_is_mem & (|(i_alu_resultE[2:0] & e_low_bits));
`else
    assign e_misalign = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Lane steering from the held address and size
    // ------------------------------------------------------------------
    logic [2:0]       m_low_bits;
    logic [OFF_W-1:0] byte_off;
    logic [OFF_W-1:0] eff_off;
    logic [OFF_W+2:0] shamt;
    logic [NB-1:0]    base_sel;
    logic [NB-1:0]    byte_sel;
    logic [XLEN-1:0]  wdata_shifted;
    logic [XLEN-1:0]  rdata_shifted;
    logic [XLEN-1:0]  load_mask;
    logic             load_sign;
    logic [XLEN-1:0]  load_ext;

    assign m_low_bits = size_low_bits(funct3_reg[1:0]);
    assign byte_off   = alu_result_reg[OFF_W-1:0];
    // Sub-size bits are dropped so that an unflagged misaligned access
    // truncates to its natural alignment.
    assign eff_off    = byte_off & ~m_low_bits[OFF_W-1:0];
    assign shamt      = {eff_off, 3'b000};

    always_comb begin
        base_sel = '1;
        case (funct3_reg[1:0])
            2'd0:    base_sel = NB'(1);
            2'd1:    base_sel = NB'(3);
            2'd2:    base_sel = NB'(15);
            default: base_sel = '1;
        endcase
    end

    assign byte_sel      = base_sel << eff_off;
    assign wdata_shifted = wdata_reg << shamt;

    // Lanes that are not written carry zero instead of leftover store bits.
    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_wlane
            assign o_dmem_wdata[gi*8 +: 8] = byte_sel[gi] ? wdata_shifted[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign rdata_shifted = i_dmem_rdata >> shamt;

    always_comb begin
        load_mask = '1;
        load_sign = rdata_shifted[XLEN-1];
        case (funct3_reg[1:0])
            2'd0: begin
                load_mask = XLEN'(8'hFF);
                load_sign = rdata_shifted[7];
            end
            2'd1: begin
                load_mask = XLEN'(16'hFFFF);
                load_sign = rdata_shifted[15];
            end
            2'd2: begin
                load_mask = XLEN'(32'hFFFF_FFFF);
                load_sign = rdata_shifted[31];
            end
            default: begin
                load_mask = '1;
                load_sign = rdata_shifted[XLEN-1];
            end
        endcase
    end

    // funct3[2] selects the unsigned variants (LBU/LHU/LWU).
    assign load_ext = (rdata_shifted & load_mask) |
                      ((~funct3_reg[2] & load_sign) ? ~load_mask : '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        valid_next      = valid_reg;
        kill_next       = kill_reg;
        tmo_cnt_next    = tmo_cnt_reg;
        reg_wr_en_next  = reg_wr_en_reg;
        result_src_next = result_src_reg;
        mem_wr_en_next  = mem_wr_en_reg;
        funct3_next     = funct3_reg;
        alu_result_next = alu_result_reg;
        wdata_next      = wdata_reg;
        rd_addr_next    = rd_addr_reg;
        pc_plus4_next   = pc_plus4_reg;
        pc_target_next  = pc_target_reg;
        readdata_next   = readdata_reg;
        bus_err_next    = bus_err_reg;
        misalign_next   = misalign_reg;

        case (state_reg)
            IDLE, DONE: begin
                if (capture) begin
                    // In DONE this also retires the current instruction,
                    // which gives back-to-back issue.
                    valid_next      = 1'b1;
                    kill_next       = 1'b0;
                    reg_wr_en_next  = i_ctrl_reg_wr_enE & ~e_misalign;
                    result_src_next = i_ctrl_result_srcE;
                    mem_wr_en_next  = i_ctrl_mem_wr_enE;
                    funct3_next     = i_funct3E;
                    alu_result_next = i_alu_resultE;
                    wdata_next      = i_mem_writedataE;
                    rd_addr_next    = i_regfile_rd_addrE;
                    pc_plus4_next   = i_PCPlus4E;
                    pc_target_next  = i_PCTargetE;
                    readdata_next   = '0;
                    bus_err_next    = 1'b0;
                    misalign_next   = e_misalign;
                    state_next      = (e_is_mem & ~e_misalign) ? REQ : IDLE;
                end else begin
                    // The instruction has been shown for its one cycle.
                    valid_next = 1'b0;
                    kill_next  = 1'b0;
                    state_next = IDLE;
                end
            end

            REQ: begin
                if (i_dmem_gnt) begin
                    // Once granted, the access cannot be withdrawn. A flush
                    // now only hides the result.
                    kill_next = kill_reg | i_flush;
                    if (mem_wr_en_reg) begin
                        state_next = DONE;
                        valid_next = valid_reg & ~(kill_reg | i_flush);
                    end else begin
                        state_next   = RESP;
                        tmo_cnt_next = '0;
                    end
                end else if (i_flush) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                end
            end

            RESP: begin
                kill_next    = kill_reg | i_flush;
                tmo_cnt_next = tmo_cnt_reg + 16'd1;
                if (i_dmem_rvalid) begin
                    readdata_next = load_ext;
                    state_next    = DONE;
                    valid_next    = valid_reg & ~(kill_reg | i_flush);
                end else if (tmo_cnt_next == 16'(TIMEOUT_CYC)) begin
                    bus_err_next   = 1'b1;
                    reg_wr_en_next = 1'b0;
                    state_next     = DONE;
                    valid_next     = valid_reg & ~(kill_reg | i_flush);
                end
            end

            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_reg      <= IDLE;
            valid_reg      <= 1'b0;
            kill_reg       <= 1'b0;
            tmo_cnt_reg    <= '0;
            reg_wr_en_reg  <= 1'b0;
            result_src_reg <= '0;
            mem_wr_en_reg  <= 1'b0;
            funct3_reg     <= '0;
            alu_result_reg <= '0;
            wdata_reg      <= '0;
            rd_addr_reg    <= '0;
            pc_plus4_reg   <= '0;
            pc_target_reg  <= '0;
            readdata_reg   <= '0;
            bus_err_reg    <= 1'b0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            valid_reg      <= valid_next;
            kill_reg       <= kill_next;
            tmo_cnt_reg    <= tmo_cnt_next;
            reg_wr_en_reg  <= reg_wr_en_next;
            result_src_reg <= result_src_next;
            mem_wr_en_reg  <= mem_wr_en_next;
            funct3_reg     <= funct3_next;
            alu_result_reg <= alu_result_next;
            wdata_reg      <= wdata_next;
            rd_addr_reg    <= rd_addr_next;
            pc_plus4_reg   <= pc_plus4_next;
            pc_target_reg  <= pc_target_next;
            readdata_reg   <= readdata_next;
            bus_err_reg    <= bus_err_next;
            misalign_reg   <= misalign_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_validM           = valid_reg & o_readyE;
    assign o_ctrl_reg_wr_enM  = reg_wr_en_reg;
    assign o_ctrl_result_srcM = result_src_reg;
    assign o_regfile_rd_addrM = rd_addr_reg;
    assign o_alu_resultM      = alu_result_reg;
    assign o_PCPlus4M         = pc_plus4_reg;
    assign o_PCTargetM        = pc_target_reg;
    assign o_mem_readdataM    = readdata_reg;
    assign o_bus_errM         = bus_err_reg;
    assign o_misalignM        = misalign_reg;

    assign o_dmem_req      = (state_reg == REQ);
    assign o_dmem_wr_en    = mem_wr_en_reg & o_dmem_req;
    assign o_dmem_addr     = {alu_result_reg[XLEN-1:OFF_W], {OFF_W{1'b0}}};
    assign o_dmem_byte_sel = byte_sel;

endmodule
